// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory read port and
// registers each fetched instruction with its PC into the IF/ID register.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instruction,
    input  logic        imem_ready,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE = 2'b10;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    // State register: reset wins over clk_en, otherwise clk_en gates every update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            valid_q     <= 1'b0;
            ifid_pc_q   <= 32'h0;
            ifid_inst_q <= NOP_INST;
            cause_q     <= CAUSE_NONE;
            fault_pc_q  <= 32'h0;
        end else if (clk_en) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            ifid_pc_q   <= ifid_pc_d;
            ifid_inst_q <= ifid_inst_d;
            cause_q     <= cause_d;
            fault_pc_q  <= fault_pc_d;
        end
    end

    // Next state; in FETCH the order is redirect, stall, range check, normal fetch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        ifid_pc_d   = ifid_pc_q;
        ifid_inst_d = ifid_inst_q;
        cause_d     = cause_q;
        fault_pc_d  = fault_pc_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                if (redirect_valid) pc_d = redirect_pc;
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_d        = redirect_pc;
                    valid_d     = 1'b0;
                    ifid_inst_d = NOP_INST;
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_d    = ST_FAULT;
                        cause_d    = CAUSE_ALIGN;
                        fault_pc_d = redirect_pc;
                    end
                end else if (stall) begin
                    state_d = ST_FETCH;
                end else if (!imem_ready) begin
                    valid_d     = 1'b0;
                    ifid_inst_d = NOP_INST;
                    state_d     = ST_FAULT;
                    cause_d     = CAUSE_RANGE;
                    fault_pc_d  = pc_q;
                end else begin
                    ifid_inst_d = imem_instruction;
                    ifid_pc_d   = pc_q;
                    valid_d     = 1'b1;
                    pc_d        = pc_q + 32'd4;
                end
            end
            ST_FAULT: begin
                valid_d     = 1'b0;
                ifid_inst_d = NOP_INST;
                if (redirect_valid) begin
                    if (redirect_pc[1:0] == 2'b00) begin
                        state_d = ST_FETCH;
                        cause_d = CAUSE_NONE;
                        pc_d    = redirect_pc;
                    end else begin
                        cause_d    = CAUSE_ALIGN;
                        fault_pc_d = redirect_pc;
                    end
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_comb begin
        imem_rd_en        = (state_q == ST_FETCH) && !stall;
        imem_addr         = {2'b00, pc_q[31:2]};
        if_id_valid       = valid_q;
        if_id_pc          = ifid_pc_q;
        if_id_instruction = ifid_inst_q;
        fetch_fault       = (state_q == ST_FAULT);
        fault_cause       = cause_q;
        fault_pc          = fault_pc_q;
        dbg_state_o       = state_q;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: combinational memory model and per-scenario tasks.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst, clk_en, stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_rd_en;
    logic [31:0] imem_addr, imem_instruction;
    logic        imem_ready, force_ready;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_instruction, fault_pc;
    logic        fetch_fault;
    logic [1:0]  fault_cause, dbg_state_o;

    int checks = 0;
    int fails  = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
        .imem_instruction(imem_instruction), .imem_ready(imem_ready),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instruction(if_id_instruction), .fetch_fault(fetch_fault),
        .fault_cause(fault_cause), .fault_pc(fault_pc), .dbg_state_o(dbg_state_o)
    );

    // Memory: 1K words in range; first four words hold the program, others 0xDEAD_<index>.
    always_comb begin
        case (imem_addr)
            32'd0:   imem_instruction = 32'h0010_0093;
            32'd1:   imem_instruction = 32'h0020_0113;
            32'd2:   imem_instruction = 32'h0030_0193;
            32'd3:   imem_instruction = 32'h0040_0213;
            default: imem_instruction = {16'hDEAD, imem_addr[15:0]};
        endcase
        imem_ready = force_ready || (imem_addr < 32'h400);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clk_en = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; force_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        checks++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b exp 0", if_id_valid); end
        checks++; if (if_id_pc !== 32'h0) begin fails++; $display("FAIL reset_if_id_pc got %h exp 0", if_id_pc); end
        checks++; if (if_id_instruction !== NOP) begin fails++; $display("FAIL reset_inst got %h exp %h", if_id_instruction, NOP); end
        checks++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %0b exp 0", fetch_fault); end
        checks++; if (fault_cause !== 2'b00) begin fails++; $display("FAIL reset_cause got %b exp 00", fault_cause); end
        checks++; if (fault_pc !== 32'h0) begin fails++; $display("FAIL reset_fault_pc got %h exp 0", fault_pc); end
        checks++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        checks++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en got %0b exp 0", imem_rd_en); end
        checks++; if (dbg_state_o !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", dbg_state_o); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_inst [4];
        exp_inst[0] = 32'h0010_0093; exp_inst[1] = 32'h0020_0113;
        exp_inst[2] = 32'h0030_0193; exp_inst[3] = 32'h0040_0213;
        do_reset();
        step();
        checks++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL boot_valid got %0b exp 0", if_id_valid); end
        checks++; if (imem_rd_en !== 1'b1) begin fails++; $display("FAIL boot_rd_en got %0b exp 1", imem_rd_en); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (if_id_pc !== 32'(4 * i)) begin fails++; $display("FAIL seq_pc[%0d] got %h exp %h", i, if_id_pc, 32'(4 * i)); end
            checks++; if (if_id_instruction !== exp_inst[i]) begin fails++; $display("FAIL seq_inst[%0d] got %h exp %h", i, if_id_instruction, exp_inst[i]); end
            checks++; if (if_id_valid !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d] got %0b exp 1", i, if_id_valid); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step(); step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (if_id_pc !== 32'h4) begin fails++; $display("FAIL stall_pc[%0d] got %h exp 4", i, if_id_pc); end
            checks++; if (imem_addr !== 32'h2) begin fails++; $display("FAIL stall_addr[%0d] got %h exp 2", i, imem_addr); end
            checks++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL stall_rd_en[%0d] got %0b exp 0", i, imem_rd_en); end
        end
        stall = 1'b0;
        step();
        checks++; if (if_id_pc !== 32'h8) begin fails++; $display("FAIL resume_pc got %h exp 8", if_id_pc); end
        checks++; if (if_id_instruction !== 32'h0030_0193) begin fails++; $display("FAIL resume_inst got %h exp 00300193", if_id_instruction); end
    endtask

    task automatic test_redirect_stall();
        redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        checks++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %0b exp 0", if_id_valid); end
        checks++; if (if_id_instruction !== NOP) begin fails++; $display("FAIL flush_inst got %h exp %h", if_id_instruction, NOP); end
        checks++; if (imem_addr !== 32'h10) begin fails++; $display("FAIL flush_addr got %h exp 10", imem_addr); end
        step();
        checks++; if (if_id_pc !== 32'h40) begin fails++; $display("FAIL target_pc got %h exp 40", if_id_pc); end
        checks++; if (if_id_instruction !== 32'hDEAD_0010) begin fails++; $display("FAIL target_inst got %h exp dead0010", if_id_instruction); end
        checks++; if (if_id_valid !== 1'b1) begin fails++; $display("FAIL target_valid got %0b exp 1", if_id_valid); end
    endtask

    task automatic test_range_fault();
        redirect_valid = 1'b1; redirect_pc = 32'hFF8;
        step();
        redirect_valid = 1'b0;
        step();
        checks++; if (if_id_pc !== 32'hFF8) begin fails++; $display("FAIL edge_pc0 got %h exp ff8", if_id_pc); end
        step();
        checks++; if (if_id_pc !== 32'hFFC) begin fails++; $display("FAIL edge_pc1 got %h exp ffc", if_id_pc); end
        checks++; if (if_id_instruction !== 32'hDEAD_03FF) begin fails++; $display("FAIL edge_inst1 got %h exp dead03ff", if_id_instruction); end
        step();
        checks++; if (fetch_fault !== 1'b1) begin fails++; $display("FAIL range_fault got %0b exp 1", fetch_fault); end
        checks++; if (fault_cause !== 2'b10) begin fails++; $display("FAIL range_cause got %b exp 10", fault_cause); end
        checks++; if (fault_pc !== 32'h1000) begin fails++; $display("FAIL range_fault_pc got %h exp 1000", fault_pc); end
        checks++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL range_valid got %0b exp 0", if_id_valid); end
        checks++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL range_rd_en got %0b exp 0", imem_rd_en); end
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        stall = 1'b0; redirect_valid = 1'b0;
        checks++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL recover_fault got %0b exp 0", fetch_fault); end
        checks++; if (fault_cause !== 2'b00) begin fails++; $display("FAIL recover_cause got %b exp 00", fault_cause); end
        checks++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL recover_addr got %h exp 0", imem_addr); end
        step();
        checks++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1) begin fails++; $display("FAIL recover_fetch got pc %h v %0b exp pc 0 v 1", if_id_pc, if_id_valid); end
        checks++; if (if_id_instruction !== 32'h0010_0093) begin fails++; $display("FAIL recover_inst got %h exp 00100093", if_id_instruction); end
    endtask

    task automatic test_misaligned_clken();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step();
        checks++; if (fetch_fault !== 1'b1 || fault_cause !== 2'b01) begin fails++; $display("FAIL align_fault got f %0b c %b exp f 1 c 01", fetch_fault, fault_cause); end
        checks++; if (fault_pc !== 32'h42) begin fails++; $display("FAIL align_fault_pc got %h exp 42", fault_pc); end
        checks++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL align_valid got %0b exp 0", if_id_valid); end
        clk_en = 1'b0; redirect_pc = 32'h80;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (fetch_fault !== 1'b1 || fault_cause !== 2'b01 || fault_pc !== 32'h42) begin fails++; $display("FAIL clken_hold[%0d] got f %0b c %b p %h exp f 1 c 01 p 42", i, fetch_fault, fault_cause, fault_pc); end
            checks++; if (dbg_state_o !== 2'd2) begin fails++; $display("FAIL clken_state[%0d] got %0d exp 2", i, dbg_state_o); end
        end
        clk_en = 1'b1; redirect_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (fetch_fault !== 1'b0 || fault_cause !== 2'b00 || fault_pc !== 32'h0) begin fails++; $display("FAIL rst_fault got f %0b c %b p %h exp 0 00 0", fetch_fault, fault_cause, fault_pc); end
        checks++; if (dbg_state_o !== 2'd0 || imem_addr !== 32'h0) begin fails++; $display("FAIL rst_state got s %0d a %h exp s 0 a 0", dbg_state_o, imem_addr); end
        checks++; if (if_id_instruction !== NOP || if_id_valid !== 1'b0 || if_id_pc !== 32'h0) begin fails++; $display("FAIL rst_ifid got i %h v %0b p %h", if_id_instruction, if_id_valid, if_id_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        force_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'h3FFF_FFFE) begin fails++; $display("FAIL boot_redirect_addr got %h exp 3ffffffe", imem_addr); end
        step();
        checks++; if (if_id_pc !== 32'hFFFF_FFF8) begin fails++; $display("FAIL wrap_pc0 got %h exp fffffff8", if_id_pc); end
        step();
        checks++; if (if_id_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pc1 got %h exp fffffffc", if_id_pc); end
        checks++; if (if_id_instruction !== 32'hDEAD_FFFF) begin fails++; $display("FAIL wrap_inst1 got %h exp deadffff", if_id_instruction); end
        checks++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
        force_ready = 1'b0;
        step();
        checks++; if (if_id_pc !== 32'h0 || if_id_instruction !== 32'h0010_0093) begin fails++; $display("FAIL wrap_pc2 got %h %h exp 0 00100093", if_id_pc, if_id_instruction); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_range_fault();
        test_misaligned_clken();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Fetch stage of the riscv-small pipeline: owns the program counter, drives the instruction memory's read port, and registers each fetched instruction with its PC into the IF/ID pipeline register consumed by decode. It handles pipeline stalls, branch/jump redirects (flush), and fetch faults (misaligned or out-of-range PC). It sits directly upstream of the instruction memory and directly upstream of decode.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned
- NOP_INST, 32'h0000_0013, instruction (addi x0,x0,0) placed in IF/ID on bubble/flush/reset

Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset; takes effect on a rising clk edge regardless of clk_en
- clk_en  in  1  clock enable; when 0 every register holds (except on rst)
- stall  in  1  hazard-unit stall; hold PC and IF/ID
- redirect_valid  in  1  branch/jump taken in a later stage; flush and reload PC
- redirect_pc  in  32 (dataBus_t)  new PC byte address
- imem_rd_en  out  1  read enable to instruction memory
- imem_addr  out  32 (dataBus_t)  word index = {2'b00, pc[31:2]}
- imem_instruction  in  32 (instruction_u)  combinational read data
- imem_ready  in  1  memory reports imem_addr valid (in range)
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  32 (dataBus_t)  byte PC of if_id_instruction
- if_id_instruction  out  32 (instruction_u)  registered instruction
- fetch_fault  out  1  fetch halted on fault
- fault_cause  out  2  00 none, 01 misaligned PC, 10 out-of-range PC
- fault_pc  out  32  PC that faulted

## Operation
- State machine: BOOT, FETCH, FAULT.
- Reset: state=BOOT, pc=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_instruction=NOP_INST, fetch_fault=0, fault_cause=00, fault_pc=0.
- All updates below occur only on edges with clk_en=1 (rst excepted).
- BOOT: imem_rd_en=0, IF/ID holds bubble; next edge -> FETCH. redirect_valid in BOOT is honoured (pc<=redirect_pc).
- FETCH: imem_rd_en=1 (0 when stall=1). Each edge, priority order:
  1. redirect_valid: pc<=redirect_pc, if_id_valid<=0, if_id_instruction<=NOP_INST; if redirect_pc[1:0]!=0 -> FAULT, cause 01, fault_pc<=redirect_pc.
  2. stall: pc, IF/ID, state hold.
  3. imem_ready=0: if_id_valid<=0, instruction<=NOP_INST, -> FAULT, cause 10, fault_pc<=pc; pc holds.
  4. otherwise: if_id_instruction<=imem_instruction, if_id_pc<=pc, if_id_valid<=1, pc<=pc+4.
- FAULT: imem_rd_en=0, fetch_fault=1, IF/ID holds bubble (valid=0), pc holds. redirect_valid with aligned target -> FETCH, fetch_fault<=0, cause<=00, pc<=redirect_pc; misaligned target stays FAULT with fault_pc/cause updated to 01. stall ignored.
- PC arithmetic: 32-bit, pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); no overflow flag.
- Redirect and stall asserted together: redirect wins (flush overrides stall).
- Reset mid-operation (any state, any stall/redirect): reset values above on that edge.
- clk_en=0 with redirect_valid=1: redirect is lost; upstream holds redirect until an enabled edge.

## Timing
- imem read is combinational: imem_addr derived combinationally from pc register; imem_instruction sampled same cycle.
- Fetch latency: instruction at pc appears on if_id_* one edge after pc is presented.
- Throughput: one instruction per enabled cycle without stall.
- Redirect penalty: edge N captures redirect (bubble in IF/ID at N), target instruction in IF/ID at edge N+1.
- First valid instruction after reset release: BOOT edge, then FETCH edge -> if_id_valid=1 two enabled edges after rst deasserts.
- fetch_fault asserts on the same edge the faulting condition is captured; deasserts on the redirect edge leaving FAULT.

## Test plan
- Reset release, RESET_PC=0, mem[0..3]=0x00100093,0x00200113,0x00300193,0x00400213 -> if_id_pc 0,4,8,12 on consecutive edges after BOOT, matching instructions, valid=1.
- stall=1 for 3 cycles while IF/ID holds PC 4 -> if_id_pc=4, pc=8 unchanged, imem_rd_en=0; resumes with PC 8 next edge.
- redirect_valid=1, redirect_pc=0x40, simultaneous stall=1 -> next edge if_id_valid=0, NOP_INST; following edge if_id_pc=0x40.
- Sequential fetch to PC 0xFFC with imem_ready=0 at 0x1000 -> FAULT, cause 10, fault_pc=0x1000, valid=0; redirect to 0x0 -> fault clears, fetch resumes at 0.
- redirect_pc=0x42 -> FAULT cause 01, fault_pc=0x42; clk_en=0 cycles interleaved hold all outputs; rst=1 in FAULT -> all reset values next edge.
- pc=0xFFFF_FFFC with imem_ready forced 1 -> next pc=0x0000_0000, if_id_pc=0xFFFF_FFFC.
